// File: rtl/cpu_mult_seq.sv
// Sequential slice-based multiplier: one partial product per cycle.
// Signed operands are handled as magnitudes with a final negation.
module cpu_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              sign1,
  input  logic              sign2,
  input  logic              sel_hi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  localparam int NS = DATA_W / SLICE_W;
  localparam int N  = NS * NS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int PW = 2 * DATA_W;

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [IW-1:0] J_LAST = IW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              neg;
  logic              hi;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     i_idx;
  logic [IW-1:0]     j_idx;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              accept;
  logic [SLICE_W-1:0]   a_sl;
  logic [SLICE_W-1:0]   b_sl;
  logic [2*SLICE_W-1:0] pp;
  logic [PW-1:0]     pp_ext;
  int                shamt;
  logic [PW-1:0]     sum;
  logic [PW-1:0]     fin;
  logic [DATA_W-1:0] res_next;

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  // Operand magnitudes and result sign at the input boundary
  always_comb begin
    a_neg = sign1 & src1[DATA_W-1];
    b_neg = sign2 & src2[DATA_W-1];
    a_in  = a_neg ? -src1 : src1;
    b_in  = b_neg ? -src2 : src2;
  end

  // Current partial product, running sum and selected final word
  always_comb begin
    a_sl   = a_mag[i_idx*SLICE_W +: SLICE_W];
    b_sl   = b_mag[j_idx*SLICE_W +: SLICE_W];
    pp     = {{SLICE_W{1'b0}}, a_sl} *
             {{SLICE_W{1'b0}}, b_sl};
    pp_ext = '0;
    pp_ext[2*SLICE_W-1:0] = pp;
    shamt  = SLICE_W * (int'(i_idx) + int'(j_idx));
    sum    = acc + (pp_ext << shamt);
    fin    = neg ? -sum : sum;
    res_next = hi ? fin[PW-1:DATA_W] : fin[DATA_W-1:0];
  end

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      cnt       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      neg       <= 1'b0;
      hi        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        MUL: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (j_idx == J_LAST) begin
            j_idx <= '0;
            i_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
          if (cnt == C_LAST) begin
            result    <= res_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        a_mag <= a_in;
        b_mag <= b_in;
        neg   <= a_neg ^ b_neg;
        hi    <= sel_hi;
        acc   <= '0;
        cnt   <= '0;
        i_idx <= '0;
        j_idx <= '0;
        state <= MUL;
      end
    end
  end

endmodule
